// File: rtl/pwm_pkg.sv
// Shared types for the PWM capture path: FSM state encoding and default counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   localparam int CNT_W_DEF = 32;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Bundle of the PWM capture control inputs and measurement outputs.
// Latency: n/a (wiring only).
// Backpressure: none; results are strobed and held, there is no ready.
// Ports: pwm_in/enable/clear flow master->slave; period_o, pulse_o, sample_stb,
//        valid_o, timeout_o and stuck_level_o flow slave->master.
interface pwm_capture_if #(
   parameter int CNT_W = pwm_pkg::CNT_W_DEF
);
   logic             pwm_in;
   logic             enable;
   logic             clear;
   logic [CNT_W-1:0] period_o;
   logic [CNT_W-1:0] pulse_o;
   logic             sample_stb;
   logic             valid_o;
   logic             timeout_o;
   logic             stuck_level_o;

   modport master (
      output pwm_in, enable, clear,
      input  period_o, pulse_o, sample_stb, valid_o, timeout_o, stuck_level_o
   );

   modport slave (
      input  pwm_in, enable, clear,
      output period_o, pulse_o, sample_stb, valid_o, timeout_o, stuck_level_o
   );
endinterface

// File: rtl/pwm_sync_edge.sv
// Synchronizes an async level input and flags its rising and falling edges.
// Latency: din edge -> rise_o/fall_o asserted after SYNC_STAGES clock edges, for one cycle.
// Backpressure: none; edges are combinational pulses, consumer must act that cycle.
// Ports: clk, rst_n (async active-low), din (async), sync_o, rise_o, fall_o.
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_o & ~prev_q;
   assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an async PWM input between successive rising edges.
// Latency: results update on the edge ending the rise-detect cycle (SYNC_STAGES+1 edges after pwm_in rises).
// Backpressure: none; each result is a one-cycle sample_stb with held period_o/pulse_o.
// Ports: PCLK, PRESETn (async active-low), bus (slave: pwm_in/enable/clear in, results out).
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int               CNT_W       = CNT_W_DEF,
   parameter int               SYNC_STAGES = 2,
   parameter logic [CNT_W-1:0] TIMEOUT     = '1
) (
   input logic          PCLK,
   input logic          PRESETn,
   pwm_capture_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] pulse_q, pulse_d;
   logic             stb_q, stb_d;
   logic             valid_q, valid_d;
   logic             tmo_q, tmo_d;
   logic             stuck_q, stuck_d;

   logic             sync, rise, fall;
   logic             tmo_hit;
   logic [CNT_W-1:0] cnt_inc;

   pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk    (PCLK),
      .rst_n  (PRESETn),
      .din    (bus.pwm_in),
      .sync_o (sync),
      .rise_o (rise),
      .fall_o (fall)
   );

   // Edges take priority over the timeout in every branch below, so tmo_hit alone
   // means "TIMEOUT reached with no edge this cycle".
   assign tmo_hit = (cnt_q == TIMEOUT);
   // Saturate so a fall landing exactly on TIMEOUT cannot wrap the counter in LOW.
   assign cnt_inc = tmo_hit ? cnt_q : cnt_q + CNT_ONE;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = bus.enable ? ARM : IDLE;
      end else if (!bus.enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = ARM;
            ARM:  if (rise) state_d = HIGH;
            HIGH: if (fall) state_d = LOW;  else if (tmo_hit) state_d = ARM;
            LOW:  if (rise) state_d = HIGH; else if (tmo_hit) state_d = ARM;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      hi_cnt_d = hi_cnt_q;
      period_d = period_q;
      pulse_d  = pulse_q;
      stb_d    = 1'b0;
      valid_d  = valid_q;
      tmo_d    = tmo_q;
      stuck_d  = stuck_q;
      if (bus.clear) begin
         valid_d = 1'b0;
         tmo_d   = 1'b0;
         stuck_d = 1'b0;
      end else if (bus.enable) begin
         case (state_q)
            ARM: if (rise) cnt_d = CNT_ONE;
            HIGH: begin
               cnt_d = cnt_inc;
               if (fall) begin
                  hi_cnt_d = cnt_q;
               end else if (tmo_hit) begin
                  tmo_d   = 1'b1;
                  stuck_d = sync;
               end
            end
            LOW: begin
               if (rise) begin
                  period_d = cnt_q;
                  pulse_d  = hi_cnt_q;
                  stb_d    = 1'b1;
                  valid_d  = 1'b1;
                  cnt_d    = CNT_ONE;
               end else begin
                  cnt_d = cnt_inc;
                  if (tmo_hit) begin
                     tmo_d   = 1'b1;
                     stuck_d = sync;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q    <= '0;
         hi_cnt_q <= '0;
         period_q <= '0;
         pulse_q  <= '0;
         stb_q    <= 1'b0;
         valid_q  <= 1'b0;
         tmo_q    <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_cnt_q <= hi_cnt_d;
         period_q <= period_d;
         pulse_q  <= pulse_d;
         stb_q    <= stb_d;
         valid_q  <= valid_d;
         tmo_q    <= tmo_d;
         stuck_q  <= stuck_d;
      end
   end

   assign bus.period_o      = period_q;
   assign bus.pulse_o       = pulse_q;
   assign bus.sample_stb    = stb_q;
   assign bus.valid_o       = valid_q;
   assign bus.timeout_o     = tmo_q;
   assign bus.stuck_level_o = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table of steady PWM patterns plus
// hand-written sequences for pattern switch, timeout, clear, enable drop and reset.
// Inputs are driven 1 time unit after each rising PCLK edge; outputs sampled there too.
module tb_pwm_capture;
   logic PCLK;
   logic PRESETn;

   pwm_capture_if #(.CNT_W(32)) bus();

   pwm_capture #(
      .CNT_W       (32),
      .SYNC_STAGES (2),
      .TIMEOUT     (32'd50)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      int p;
      int h;
      int n;
      int exp_stb;
      int exp_p;
      int exp_h;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int stb_cnt, odd_cnt, dbl_cnt;
   int last_p, last_h;
   int exp_p, exp_h;
   bit chk_vals;
   bit prev_stb;
   int sp_q[$];
   int sh_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
      if (bus.sample_stb) begin
         stb_cnt++;
         last_p = int'(bus.period_o);
         last_h = int'(bus.pulse_o);
         sp_q.push_back(last_p);
         sh_q.push_back(last_h);
         if (chk_vals && (last_p != exp_p || last_h != exp_h)) odd_cnt++;
         if (prev_stb) dbl_cnt++;
      end
      prev_stb = bus.sample_stb;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_period(input int p, input int h, input int clr_at, input int dis_at);
      for (int i = 0; i < p; i++) begin
         bus.pwm_in = (i < h);
         bus.clear  = (i == clr_at);
         bus.enable = (i != dis_at);
         tick();
      end
      bus.clear  = 1'b0;
      bus.enable = 1'b1;
   endtask

   task automatic clean_arm();
      bus.enable = 1'b0;
      bus.pwm_in = 1'b0;
      ticks(4);
      bus.enable = 1'b1;
      tick();
   endtask

   task automatic flush();
      bus.pwm_in = 1'b0;
      ticks(6);
   endtask

   task automatic reset_counts();
      stb_cnt = 0;
      odd_cnt = 0;
      sp_q.delete();
      sh_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_period"}, bus.period_o, 0);
      check({tag, "_pulse"}, bus.pulse_o, 0);
      check({tag, "_stb"}, bus.sample_stb, 0);
      check({tag, "_valid"}, bus.valid_o, 0);
      check({tag, "_timeout"}, bus.timeout_o, 0);
      check({tag, "_stuck"}, bus.stuck_level_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   odd;
      vecs[0] = '{p:10, h:3,  n:5, exp_stb:4, exp_p:10, exp_h:3};
      vecs[1] = '{p:4,  h:1,  n:4, exp_stb:3, exp_p:4,  exp_h:1};
      vecs[2] = '{p:2,  h:1,  n:6, exp_stb:5, exp_p:2,  exp_h:1};
      vecs[3] = '{p:20, h:15, n:3, exp_stb:2, exp_p:20, exp_h:15};
      vecs[4] = '{p:7,  h:6,  n:4, exp_stb:3, exp_p:7,  exp_h:6};

      chk_vals = 1'b0;
      prev_stb = 1'b0;
      dbl_cnt  = 0;
      exp_p = 0;
      exp_h = 0;
      reset_counts();
      bus.pwm_in = 1'b0;
      bus.enable = 1'b0;
      bus.clear  = 1'b0;
      PRESETn = 1'b0;
      ticks(3);
      check_all_zero("reset");
      PRESETn = 1'b1;
      ticks(2);

      // Steady patterns, each from a fresh arm: first rise gives no sample.
      foreach (vecs[k]) begin
         clean_arm();
         reset_counts();
         chk_vals = 1'b1;
         exp_p = vecs[k].p;
         exp_h = vecs[k].h;
         for (int j = 0; j < vecs[k].n; j++) run_period(vecs[k].p, vecs[k].h, -1, -1);
         flush();
         chk_vals = 1'b0;
         check($sformatf("vec%0d_stb_count", k), stb_cnt, vecs[k].exp_stb);
         check($sformatf("vec%0d_period", k), last_p, vecs[k].exp_p);
         check($sformatf("vec%0d_pulse", k), last_h, vecs[k].exp_h);
         check($sformatf("vec%0d_odd_values", k), odd_cnt, 0);
         check($sformatf("vec%0d_valid", k), bus.valid_o, 1);
      end

      // Pattern switch without re-arm.
      clean_arm();
      reset_counts();
      for (int j = 0; j < 3; j++) run_period(10, 3, -1, -1);
      for (int j = 0; j < 4; j++) run_period(20, 15, -1, -1);
      flush();
      odd = 0;
      foreach (sp_q[i])
         if (!((sp_q[i] == 10 && sh_q[i] == 3) || (sp_q[i] == 20 && sh_q[i] == 15))) odd++;
      check("switch_stb_count", stb_cnt, 6);
      check("switch_period", last_p, 20);
      check("switch_pulse", last_h, 15);
      check("switch_mixed_le1", (odd <= 1), 1);

      // Hold high after a rise: timeout exactly 50 cycles after the rise detect.
      clean_arm();
      reset_counts();
      for (int j = 0; j < 3; j++) run_period(10, 3, -1, -1);
      bus.pwm_in = 1'b1;
      ticks(52);
      check("tmo_hi_not_yet", bus.timeout_o, 0);
      tick();
      check("tmo_hi_fired", bus.timeout_o, 1);
      check("tmo_hi_stuck", bus.stuck_level_o, 1);
      check("tmo_hi_period_held", bus.period_o, 10);
      check("tmo_hi_pulse_held", bus.pulse_o, 3);
      check("tmo_hi_valid_held", bus.valid_o, 1);
      bus.pwm_in = 1'b0;
      ticks(3);
      reset_counts();
      for (int j = 0; j < 3; j++) run_period(8, 2, -1, -1);
      flush();
      check("tmo_restore_stb_count", stb_cnt, 2);
      check("tmo_restore_period", last_p, 8);
      check("tmo_restore_pulse", last_h, 2);
      check("tmo_restore_sticky", bus.timeout_o, 1);

      // clear in the rise-detect cycle while in LOW.
      for (int j = 0; j < 2; j++) run_period(10, 3, -1, -1);
      reset_counts();
      run_period(10, 3, 2, -1);
      check("clr_no_stb", stb_cnt, 0);
      check("clr_valid", bus.valid_o, 0);
      check("clr_timeout", bus.timeout_o, 0);
      check("clr_stuck", bus.stuck_level_o, 0);
      check("clr_period_kept", bus.period_o, 10);
      run_period(10, 3, -1, -1);
      check("clr_rearm_first_edge", stb_cnt, 0);
      run_period(10, 3, -1, -1);
      flush();
      check("clr_rearm_stb", stb_cnt, 1);
      check("clr_rearm_period", last_p, 10);
      check("clr_rearm_valid", bus.valid_o, 1);

      // Input stuck low: timeout with stuck level 0.
      ticks(60);
      check("tmo_lo_fired", bus.timeout_o, 1);
      check("tmo_lo_stuck", bus.stuck_level_o, 0);

      // One-cycle enable drop mid-HIGH.
      for (int j = 0; j < 3; j++) run_period(10, 3, -1, -1);
      run_period(10, 3, -1, 4);
      reset_counts();
      chk_vals = 1'b1;
      exp_p = 10;
      exp_h = 3;
      run_period(10, 3, -1, -1);
      check("endrop_first_new_rise", stb_cnt, 0);
      for (int j = 0; j < 2; j++) run_period(10, 3, -1, -1);
      flush();
      chk_vals = 1'b0;
      check("endrop_stb_count", stb_cnt, 2);
      check("endrop_values", odd_cnt, 0);
      check("endrop_period", last_p, 10);

      // Asynchronous reset mid-LOW.
      for (int j = 0; j < 2; j++) run_period(10, 3, -1, -1);
      bus.pwm_in = 1'b1;
      ticks(3);
      bus.pwm_in = 1'b0;
      ticks(3);
      #3;
      PRESETn = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick();
      PRESETn = 1'b1;
      reset_counts();
      for (int j = 0; j < 4; j++) run_period(4, 1, -1, -1);
      flush();
      check("post_rst_stb_count", stb_cnt, 3);
      check("post_rst_period", last_p, 4);
      check("post_rst_pulse", last_h, 1);
      check("post_rst_valid", bus.valid_o, 1);

      check("no_back_to_back_stb", dbl_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
